kamacore_mem_loader: RTL and testbench
======================================

# kamacore_mem_loader

Byte-stream program loader: the write-side initiator for the kamacore dual-port instruction/data memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into CPU_WIDTH words, and writes them into memory via the write port (we/a/di) starting at a programmable base address. Optional read-back verification through the memory's asynchronous dual-port read (dpra/dpo). Sits between the boot/debug byte source and the memory; the core is held in reset while the loader is busy.

## Interface
- MEM_ADDR_WIDTH, default ADDR_WIDTH: memory word-address width; must equal the memory instance's.
- CPU_WIDTH is the package constant, fixed at 32; bytes per word = 4.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  begin a load; sampled in IDLE, DONE, ERROR; ignored otherwise.
- abort  in  1  cancel load; return to IDLE next cycle, no further writes.
- base_addr  in  MEM_ADDR_WIDTH  first word address, latched on start.
- word_count  in  MEM_ADDR_WIDTH+1  words to load, latched on start.
- in_valid  in  1  byte available.
- in_data  in  8  byte.
- in_ready  out  1  loader accepts byte this cycle.
- mem_we  out  1  memory write enable.
- mem_a  out  MEM_ADDR_WIDTH  memory write address.
- mem_di  out  CPU_WIDTH  memory write data.
- mem_dpra  out  MEM_ADDR_WIDTH  memory read-back address.
- mem_dpo  in  CPU_WIDTH  memory read-back data (asynchronous).
- busy  out  1  state is LOAD, WRITE or VERIFY.
- done  out  1  state is DONE.
- error  out  1  state is ERROR.
- words_written  out  MEM_ADDR_WIDTH+1  words committed in the current/last load.

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch base_addr, word_count; clear words_written, byte index, word buffer. Go to DONE if word_count==0, else LOAD.
- LOAD: in_ready=1. On in_valid&&in_ready, write in_data into buffer byte lane [byte_idx] (byte 0 -> bits 7:0), increment byte_idx. On the 4th byte go to WRITE, byte_idx -> 0.
- WRITE: mem_we=1, mem_a=base+words_written (mod 2^MEM_ADDR_WIDTH; wrap permitted), mem_di=buffer. Then VERIFY if LOADER_VERIFY_EN is defined, else increment words_written and go to LOAD, or DONE when the new count equals word_count.
- VERIFY: mem_dpra=address just written; compare mem_dpo to buffer. Match: increment words_written, go to LOAD or DONE as above. Mismatch: go to ERROR, words_written unchanged.
- mem_we is 0 in every state except WRITE; mem_a, mem_di, mem_dpra hold the last values outside WRITE/VERIFY.
- abort has priority over all transitions except reset; a partial word is discarded; abort in IDLE is a no-op.
- start and abort in the same cycle: abort wins.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_a 0, mem_di 0, mem_dpra 0, busy 0, done 0, error 0, words_written 0, internal buffer/index 0.
- start in cycle N -> busy=1 from cycle N+1.
- 4th byte accepted in cycle N -> mem_we=1 in cycle N+1 only; in_ready=0 in N+1 (and N+2 with verify).
- Throughput per word: 5 cycles (6 with verify) at full in_valid.
- Last word: done=1 from the cycle after WRITE (after VERIFY with verify); held until start or reset.
- in_ready is a function of state only (no combinational path from in_valid).
- Reset mid-load: next cycle IDLE; no write issued in the reset cycle.

## Configuration
- LOADER_VERIFY_EN defined: VERIFY state present, mem_dpra driven, mismatch -> ERROR.
- Not defined: no VERIFY state, mem_dpra tied 0, mem_dpo unused, error constantly 0.

## Test plan
- base_addr=0x010, word_count=2, bytes 13 00 70 00 EF BE AD DE -> writes 0x00700013 @0x010, 0xDEADBEEF @0x011; done=1, words_written=2.
- word_count=0, start -> done=1 next cycle, no mem_we pulse, in_ready never 1.
- base_addr=0x3FF (MEM_ADDR_WIDTH=10), word_count=2 -> writes at 0x3FF then 0x000.
- in_valid toggled 1/0 every cycle, 1 word -> same data written; mem_we exactly one cycle after the 4th accepted byte.
- 2 bytes sent, then abort -> IDLE next cycle, no mem_we; new start loads 0x11223344 correctly from fresh byte 0.
- With LOADER_VERIFY_EN, testbench forces mem_dpo=0 during VERIFY for word 0x12345678 -> error=1, words_written=0, no further writes.

Source files
------------

// File: rtl/kamacore_mem_loader.sv
// kamacore_mem_loader: packs a little-endian byte stream into 32-bit words and writes them to kamacore memory.
// Optional read-back check of every written word is compiled in with `define LOADER_VERIFY_EN.
module kamacore_mem_loader #(
    parameter int MEM_ADDR_WIDTH = 10,
    localparam int CPU_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM_ADDR_WIDTH:0]   word_count,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a,
    output logic [CPU_WIDTH-1:0]      mem_di,
    output logic [MEM_ADDR_WIDTH-1:0] mem_dpra,
    input  logic [CPU_WIDTH-1:0]      mem_dpo,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [MEM_ADDR_WIDTH:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_byte_idx;
    logic [CPU_WIDTH-1:0]      r_buf;
    logic [MEM_ADDR_WIDTH-1:0] r_base;
    logic [MEM_ADDR_WIDTH:0]   r_count;
    logic [MEM_ADDR_WIDTH:0]   r_words;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_a;
    logic [CPU_WIDTH-1:0]      r_mem_di;
`ifdef LOADER_VERIFY_EN
    logic [MEM_ADDR_WIDTH-1:0] r_mem_dpra;
`endif

    logic [CPU_WIDTH-1:0]      w_word;
    logic [MEM_ADDR_WIDTH:0]   w_words_next;
    logic [MEM_ADDR_WIDTH-1:0] w_wr_addr;
    logic                      w_last;

    // Buffer with the incoming byte already merged into its lane, so the 4th byte goes straight to mem_di.
    always_comb begin
        w_word = r_buf;
        w_word[{r_byte_idx, 3'b000} +: 8] = in_data;
    end

    assign w_words_next = r_words + 1;
    assign w_wr_addr    = r_base + r_words[MEM_ADDR_WIDTH-1:0];
    assign w_last       = (w_words_next == r_count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_buf      <= '0;
            r_base     <= '0;
            r_count    <= '0;
            r_words    <= '0;
            r_mem_a    <= '0;
            r_mem_di   <= '0;
`ifdef LOADER_VERIFY_EN
            r_mem_dpra <= '0;
`endif
        end else if (abort) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_count    <= word_count;
                        r_words    <= '0;
                        r_byte_idx <= '0;
                        r_buf      <= '0;
                        r_state    <= (word_count == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_buf <= w_word;
                        if (r_byte_idx == 2'd3) begin
                            r_byte_idx <= '0;
                            r_mem_a    <= w_wr_addr;
                            r_mem_di   <= w_word;
`ifdef LOADER_VERIFY_EN
                            r_mem_dpra <= w_wr_addr;
`endif
                            r_state    <= S_WRITE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1;
                        end
                    end
                end
                S_WRITE: begin
`ifdef LOADER_VERIFY_EN
                    r_state <= S_VERIFY;
`else
                    r_words <= w_words_next;
                    r_state <= w_last ? S_DONE : S_LOAD;
`endif
                end
`ifdef LOADER_VERIFY_EN
                // Read-back is asynchronous, so the word written last cycle is visible on mem_dpo now.
                S_VERIFY: begin
                    if (mem_dpo == r_mem_di) begin
                        r_words <= w_words_next;
                        r_state <= w_last ? S_DONE : S_LOAD;
                    end else begin
                        r_state <= S_ERROR;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == S_LOAD);
    assign mem_we        = (r_state == S_WRITE);
    assign mem_a         = r_mem_a;
    assign mem_di        = r_mem_di;
    assign busy          = (r_state == S_LOAD) || (r_state == S_WRITE) || (r_state == S_VERIFY);
    assign done          = (r_state == S_DONE);
    assign words_written = r_words;

`ifdef LOADER_VERIFY_EN
    assign mem_dpra = r_mem_dpra;
    assign error    = (r_state == S_ERROR);
`else
    logic w_unused_dpo;
    assign w_unused_dpo = ^mem_dpo;
    assign mem_dpra     = '0;
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_kamacore_mem_loader.sv
// Directed bench for kamacore_mem_loader with a small asynchronous-read memory model.
module tb_kamacore_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_a;
    logic [31:0] mem_di;
    logic [9:0]  mem_dpra;
    logic [31:0] mem_dpo;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_written;

    int n_tests = 0;
    int n_fail  = 0;

    kamacore_mem_loader #(.MEM_ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        force_dpo_zero = 1'b0;
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_di;
    assign mem_dpo = force_dpo_zero ? 32'h0 : mem[mem_dpra];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write log and write-timing monitor, sampled on the falling edge.
    logic [9:0]  wr_a [0:15];
    logic [31:0] wr_d [0:15];
    int          n_wr = 0;
    int          lane = 0;
    bit          exp_we = 1'b0;
    bit          rdy_seen = 1'b0;

    always @(negedge clk) begin
        if (exp_we) chk("we_after_4th_byte", mem_we, 1);
        else if (mem_we) chk("we_unexpected", mem_we, 0);
        if (mem_we && n_wr < 16) begin
            wr_a[n_wr] = mem_a;
            wr_d[n_wr] = mem_di;
            n_wr++;
        end
        if (in_ready) rdy_seen = 1'b1;
        exp_we = 1'b0;
        if (!rst_n || abort) lane = 0;
        else if (in_valid && in_ready) begin
            if (lane == 3) begin
                lane   = 0;
                exp_we = 1'b1;
            end else begin
                lane++;
            end
        end
    end

    task automatic start_load(input logic [9:0] b, input logic [10:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] s, input int nb, input bit toggle);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        bit acc;
        while (i < nb && guard < 200) begin
            if (toggle && ph) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data  = s[63-8*i -: 8];
            end
            ph = ~ph;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        chk("send_bytes_accepted", i, nb);
    endtask

    task automatic wait_end(input string name);
        int k = 0;
        while (!(done || error) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_end_reached"}, (done || error), 1);
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [10:0] cnt;
        logic [63:0] stream;
        bit          toggle;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic [9:0]  a1;
        logic [31:0] d1;
    } vec_t;

    vec_t vec [4];

    initial begin
        // bytes are sent MSB-first out of 'stream'
        vec[0] = '{10'h010, 11'd2, 64'h13007000_EFBEADDE, 1'b0, 10'h010, 32'h00700013, 10'h011, 32'hDEADBEEF};
        vec[1] = '{10'h3FF, 11'd2, 64'h78563412_04030201, 1'b0, 10'h3FF, 32'h12345678, 10'h000, 32'h01020304};
        vec[2] = '{10'h123, 11'd1, 64'h44332211_00000000, 1'b1, 10'h123, 32'h11223344, 10'h000, 32'h0};
        vec[3] = '{10'h200, 11'd2, 64'hAABBCCDD_00FF00FF, 1'b1, 10'h200, 32'hDDCCBBAA, 10'h201, 32'hFF00FF00};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0; in_valid = 1'b0; in_data = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_di", mem_di, 0);
        chk("rst_mem_dpra", mem_dpra, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words_written", words_written, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            n_wr = 0;
            start_load(vec[v].base, vec[v].cnt);
            chk($sformatf("v%0d_busy_after_start", v), busy, 1);
            send_bytes(vec[v].stream, 4 * int'(vec[v].cnt), vec[v].toggle);
            wait_end($sformatf("v%0d", v));
            chk($sformatf("v%0d_num_writes", v), n_wr, vec[v].cnt);
            chk($sformatf("v%0d_addr0", v), wr_a[0], vec[v].a0);
            chk($sformatf("v%0d_data0", v), wr_d[0], vec[v].d0);
            if (vec[v].cnt > 1) begin
                chk($sformatf("v%0d_addr1", v), wr_a[1], vec[v].a1);
                chk($sformatf("v%0d_data1", v), wr_d[1], vec[v].d1);
            end
            chk($sformatf("v%0d_done", v), done, 1);
            chk($sformatf("v%0d_error", v), error, 0);
            chk($sformatf("v%0d_busy", v), busy, 0);
            chk($sformatf("v%0d_words_written", v), words_written, vec[v].cnt);
        end
`ifndef LOADER_VERIFY_EN
        chk("dpra_tied_zero", mem_dpra, 0);
`endif

        // Zero-length load finishes immediately without writing.
        n_wr = 0;
        rdy_seen = 1'b0;
        start_load(10'h100, 11'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_no_write", n_wr, 0);
        chk("zero_no_ready", rdy_seen, 0);
        chk("zero_words_written", words_written, 0);

        // Abort with a partial word, then reload from a clean byte 0.
        n_wr = 0;
        start_load(10'h050, 11'd1);
        send_bytes(64'hAABB0000_00000000, 2, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_write", n_wr, 0);
        start_load(10'h051, 11'd1);
        send_bytes(64'h44332211_00000000, 4, 1'b0);
        wait_end("reload");
        chk("reload_num_writes", n_wr, 1);
        chk("reload_addr", wr_a[0], 10'h051);
        chk("reload_data", wr_d[0], 32'h11223344);

        // start and abort together from DONE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);

        // Reset while the 4th byte is offered: no write.
        n_wr = 0;
        start_load(10'h200, 11'd1);
        send_bytes(64'h01020304_00000000, 3, 1'b0);
        in_valid = 1'b1; in_data = 8'h55; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_words_written", words_written, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_write", n_wr, 0);

`ifdef LOADER_VERIFY_EN
        // Corrupted read-back stops the load in ERROR.
        n_wr = 0;
        force_dpo_zero = 1'b1;
        start_load(10'h080, 11'd2);
        send_bytes(64'h78563412_00000000, 4, 1'b0);
        in_valid = 1'b1; in_data = 8'hA5;
        wait_end("verify");
        chk("verify_error", error, 1);
        chk("verify_done", done, 0);
        chk("verify_words_written", words_written, 0);
        chk("verify_dpra", mem_dpra, 10'h080);
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("verify_num_writes", n_wr, 1);
        chk("verify_data", wr_d[0], 32'h12345678);
        force_dpo_zero = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
